// File: rtl/attopu_pkg.sv
// Shared attopu definitions: fetch state encoding, next-PC select codes and
// the machine word width used by fetch and decode.
package attopu_pkg;

  localparam int WORD_W = 16;

  // Fixed encodings keep the state register compatible with older netlists.
  localparam logic [1:0] ST_RST_WAIT = 2'd0;
  localparam logic [1:0] ST_FETCH    = 2'd1;
  localparam logic [1:0] ST_EXEC     = 2'd2;

  typedef enum logic [1:0] {
    RST_WAIT = ST_RST_WAIT,
    FETCH    = ST_FETCH,
    EXEC     = ST_EXEC
  } fetchState_e;

  // Bit 1 alone selects the register target, so 2'b11 also means register.
  localparam logic [1:0] NPC_INC = 2'b00;
  localparam logic [1:0] NPC_REL = 2'b01;
  localparam logic [1:0] NPC_REG = 2'b10;

endpackage

// File: rtl/attopu_pc_next.sv
// Combinational next-PC selection: increment, PC-relative branch, or
// register-indirect target. All sums wrap modulo 2^16.
module attopu_pc_next
  import attopu_pkg::*;
(
  input  logic [WORD_W-1:0] pc,
  input  logic [1:0]        next_pc_sel,
  input  logic [WORD_W-1:0] branch_addr,
  input  logic [WORD_W-1:0] reg_target,
  output logic [WORD_W-1:0] pc_next
);

  always_comb begin
    pc_next = pc + WORD_W'(1);
    if ((next_pc_sel & NPC_REG) != 2'b00) begin
      pc_next = reg_target;
    end else if (next_pc_sel == NPC_INC) begin
      pc_next = pc + WORD_W'(1);
    end else begin
      // Relative offsets are taken from the branch instruction's own address.
      pc_next = pc + branch_addr;
    end
  end

endmodule

// File: rtl/attopu_fetch.sv
// attopu instruction fetch stage: PC, req/ack memory handshake, instruction
// register. Define ATTOPU_FETCH_PERFCNT_EN to add retired/stall counters.
module attopu_fetch
  import attopu_pkg::*;
#(
  parameter logic [WORD_W-1:0] RESET_PC = 16'h0000
) (
  input  logic              clk,
  input  logic              reset,
  output logic              imem_req,
  output logic [WORD_W-1:0] imem_addr,
  input  logic              imem_ack,
  input  logic [WORD_W-1:0] imem_rdata,
  output logic [WORD_W-1:0] instr,
  output logic              instr_valid,
  output logic [WORD_W-1:0] pc,
  input  logic [1:0]        next_pc_sel,
  input  logic [WORD_W-1:0] branch_addr,
  input  logic [WORD_W-1:0] reg_target,
  input  logic              stall
`ifdef ATTOPU_FETCH_PERFCNT_EN
  ,
  output logic [15:0]       retired_cnt,
  output logic [15:0]       stall_cnt
`endif
);

  fetchState_e       stateReg;
  logic [WORD_W-1:0] pcNext;
  logic              execRetire;

  attopu_pc_next uPcNext (
    .pc          (pc),
    .next_pc_sel (next_pc_sel),
    .branch_addr (branch_addr),
    .reg_target  (reg_target),
    .pc_next     (pcNext)
  );

  assign imem_addr  = pc;
  assign execRetire = (stateReg == EXEC) && !stall;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      stateReg    <= RST_WAIT;
      pc          <= RESET_PC;
      instr       <= '0;
      instr_valid <= 1'b0;
      imem_req    <= 1'b0;
    end else begin
      case (stateReg)
        RST_WAIT: begin
          imem_req <= 1'b1;
          stateReg <= FETCH;
        end
        FETCH: begin
          // Acks are only honoured here, so stale or spurious ones never land.
          if (imem_ack) begin
            instr       <= imem_rdata;
            imem_req    <= 1'b0;
            instr_valid <= 1'b1;
            stateReg    <= EXEC;
          end
        end
        EXEC: begin
          if (execRetire) begin
            pc          <= pcNext;
            instr_valid <= 1'b0;
            imem_req    <= 1'b1;
            stateReg    <= FETCH;
          end
        end
        default: begin
          imem_req    <= 1'b0;
          instr_valid <= 1'b0;
          stateReg    <= RST_WAIT;
        end
      endcase
    end
  end

`ifdef ATTOPU_FETCH_PERFCNT_EN
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      retired_cnt <= '0;
      stall_cnt   <= '0;
    end else begin
      if (execRetire) begin
        retired_cnt <= retired_cnt + 16'd1;
      end
      if (((stateReg == FETCH) && !imem_ack) || ((stateReg == EXEC) && stall)) begin
        stall_cnt <= stall_cnt + 16'd1;
      end
    end
  end
`endif

endmodule

// File: doc/attopu_fetch.md
# attopu_fetch

Instruction fetch stage of the attopu core, directly upstream of the instruction decoder. Owns the program counter, issues requests to instruction memory with a req/ack handshake, holds the fetched word in an instruction register presented to the decoder, and computes the next PC from the decoder's `nextPCSel`/`addr` outputs and the register-file value. Provides one instruction at a time, strictly in order, and stalls on a slow memory or an execute-side `stall`.

## Interface
- `RESET_PC`, 16'h0000, PC value loaded on reset.
- `clk`  in  1  single clock, rising edge.
- `reset`  in  1  asynchronous, active-high reset.
- `imem_req`  out  1  registered fetch request, held until ack.
- `imem_addr`  out  16  fetch address, equals `pc` while `imem_req`=1.
- `imem_ack`  in  1  memory returns `imem_rdata` valid this cycle.
- `imem_rdata`  in  16  instruction word.
- `instr`  out  16  instruction register, drives the decoder.
- `instr_valid`  out  1  `instr` is live for execution this cycle.
- `pc`  out  16  address of the instruction in `instr`.
- `next_pc_sel`  in  2  from decoder: 00 increment, 01 relative, 1x register.
- `branch_addr`  in  16  from decoder `addr` (already sign-extended).
- `reg_target`  in  16  register-file read value for register branch.
- `stall`  in  1  execute not ready; hold current instruction.

## Operation
- States: `RST_WAIT`, `FETCH`, `EXEC`.
- `RST_WAIT`: entered on reset; exits to `FETCH` on the first clock after reset deasserts, setting `imem_req`=1.
- `FETCH`: `imem_req`=1, `imem_addr`=`pc`. On `imem_ack`=1: `instr`<=`imem_rdata`, `imem_req`<=0, go to `EXEC`. Without ack, stay; the address is held stable.
- `EXEC`: `instr_valid`=1. If `stall`=1, stay in `EXEC`; `instr` and `pc` are unchanged. If `stall`=0: `pc`<=next PC, `imem_req`<=1, go to `FETCH`.
- Next PC is taken from `next_pc_sel` in the retiring `EXEC` cycle:
  - 00: `pc`+1.
  - 01: `pc`+`branch_addr`, relative to the branch's own address.
  - 1x: `reg_target`.
- All arithmetic is 16-bit modulo 2^16; 16'hFFFF+1 wraps to 0 with no flag.
- `imem_ack` is ignored outside `FETCH`.
- Reset values: `pc`=`RESET_PC`, `instr`=0, `instr_valid`=0, `imem_req`=0, state=`RST_WAIT`.
- Reset mid-fetch abandons the request. An ack arriving during or after reset before the next `FETCH` is discarded.

## Timing
- Zero-wait memory (ack in the first `FETCH` cycle): 2 cycles per instruction.
- Each memory wait cycle or `stall` cycle adds 1 cycle.
- `instr_valid` rises the cycle after the ack edge.
- `imem_req` rises the cycle after the `EXEC` retire edge.
- `instr_valid` and `imem_req` are never both 1.

## Configuration
- `ATTOPU_FETCH_PERFCNT_EN` defined: adds outputs `retired_cnt[15:0]` and `stall_cnt[15:0]`, both reset to 0 and wrapping.
  - `retired_cnt` increments on each `EXEC` exit.
  - `stall_cnt` increments on each `FETCH` cycle without ack and each `EXEC` cycle with `stall`=1.
- Undefined: these counters and ports are absent; all other behaviour is identical.

## Structure
- `attopu_pkg` holds:
  - the fetch state enum;
  - next-PC select constants `NPC_INC`=2'b00, `NPC_REL`=2'b01, `NPC_REG`=2'b10 (decode on bit 1 for register);
  - the 16-bit word-width constant shared with the decoder.
- Sub-module `attopu_pc_next`: combinational next-PC mux/adder (`pc`, `next_pc_sel`, `branch_addr`, `reg_target` -> `pc_next`).

## Test plan
- Reset with `RESET_PC`=16'h0010, zero-wait memory -> `imem_addr` sequence 0x0010, 0x0011, 0x0012; `instr_valid` every other cycle.
- Memory acks 3 cycles after request -> `imem_addr` held stable for 3 cycles; `instr` latches `imem_rdata` at the ack; 4-cycle fetch plus 1-cycle `EXEC`.
- `pc`=0x0020, `next_pc_sel`=01, `branch_addr`=16'hFFFC -> next fetch at 0x001C. `pc`=0xFFFF with sel=00 -> next fetch at 0x0000.
- `next_pc_sel`=10, `reg_target`=0x1234 -> next fetch at 0x1234. A spurious `imem_ack` during `EXEC` leaves `instr` unchanged.
- `stall`=1 for 2 cycles in `EXEC` -> `instr`/`pc` held, `instr_valid`=1 throughout, no `imem_req`; fetch resumes one cycle after `stall` drops.
- `reset` asserted mid-`FETCH`, ack arrives during reset -> ack discarded, outputs at reset values, first post-reset fetch at `RESET_PC`. With `ATTOPU_FETCH_PERFCNT_EN` defined, both counters read 0.
